// File: rtl/mips_loader_pkg.sv
// mips_loader_pkg
//  Shared definitions for the instruction-memory loader: the loader state
//  encoding and the fixed word geometry (32-bit instructions, 4 bytes each).
//  Optional feature macro used by the loader: LOADER_CHECKSUM_EN.
package mips_loader_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// byte_packer
//  Collects a big-endian byte stream into 32-bit words. The first byte of a
//  word lands in [31:24]. When the fourth byte arrives the complete word is
//  registered and word_valid pulses for exactly one cycle.
// Ports
//  clk        in   rising-edge clock
//  rst        in   asynchronous active-low reset
//  clear      in   drop any partial word and restart at byte 0
//  byte_valid in   byte_in is consumed this cycle
//  byte_in    in   stream byte
//  last_byte  out  the next consumed byte completes a word
//  word       out  most recently completed word (held until the next one)
//  word_valid out  one-cycle pulse, the cycle after the completing byte
module byte_packer
    import mips_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_in,
    output logic                  last_byte,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_valid
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_WIDTH-9:0] shift_q, shift_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  valid_q, valid_d;

    assign last_byte  = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign word       = word_q;
    assign word_valid = valid_q;

    // The shift register only needs the first three bytes; the fourth is
    // concatenated straight into the output word. Stale bytes left in the
    // shift register are pushed out by the next three bytes.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            if (last_byte) begin
                word_d  = {shift_q, byte_in};
                valid_d = 1'b1;
                cnt_d   = '0;
            end else begin
                shift_d = {shift_q[WORD_WIDTH-17:0], byte_in};
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//  Writer side of the instruction memory. Accepts a program image as a byte
//  stream: a 16-bit big-endian word count N, then 4*N payload bytes. Words are
//  written to consecutive addresses from 0 and the processor is held in reset
//  until the whole image is in place.
//  Optional: LOADER_CHECKSUM_EN adds a trailing byte that must equal the XOR
//  of all payload bytes; a mismatch ends the load in the error state.
// Ports
//  clk          in   rising-edge clock
//  rst          in   asynchronous active-low reset
//  start        in   one-cycle pulse, begins a load (ignored while busy)
//  in_data      in   stream byte
//  in_valid     in   in_data valid
//  in_ready     out  loader can consume a byte this cycle
//  imem_we      out  one-cycle write strobe per word
//  imem_addr    out  word address of the write
//  imem_wdata   out  word to write
//  cpu_rst      out  processor reset, high unless the load completed
//  busy         out  load in progress
//  done         out  image loaded, sticky until next start
//  error        out  load aborted, sticky until next start
//  words_loaded out  words written in the current/last load
module instr_mem_loader
    import mips_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0] imem_wdata,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e AFTER_PAYLOAD = CHECK;
`else
    localparam loader_state_e AFTER_PAYLOAD = DONE;
`endif

    loader_state_e         state_q, state_d;
    logic [7:0]            hdr_hi_q, hdr_hi_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            chk_q, chk_d;
`endif

    logic                  accept;
    logic                  start_ok;
    logic                  payload_byte;
    logic                  last_byte;
    logic [15:0]           hdr_n;
    logic [ADDR_WIDTH:0]   words_inc;

    assign in_ready = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                      (state_q == DATA)   || (state_q == CHECK);
    assign busy     = in_ready;
    assign done     = (state_q == DONE);
    assign error    = (state_q == ERR);
    assign cpu_rst  = (state_q != DONE);

    assign accept       = in_valid && in_ready;
    assign start_ok     = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign payload_byte = accept && (state_q == DATA);
    assign hdr_n        = {hdr_hi_q, in_data};
    assign words_inc    = words_q + (ADDR_WIDTH + 1)'(1);

    assign imem_addr    = addr_q;
    assign words_loaded = words_q;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_valid (payload_byte),
        .byte_in    (in_data),
        .last_byte  (last_byte),
        .word       (imem_wdata),
        .word_valid (imem_we)
    );

    // Next-state logic. The write address and word count advance on the same
    // edge that registers a completed word, so during the write cycle the
    // address is the word index and words_loaded already includes the word.
    always_comb begin
        state_d  = state_q;
        hdr_hi_d = hdr_hi_q;
        count_d  = count_q;
        words_d  = words_q;
        addr_d   = addr_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d    = chk_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_ok) begin
                    state_d = HDR_HI;
                    words_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            HDR_HI: begin
                if (accept) begin
                    hdr_hi_d = in_data;
                    state_d  = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    if (hdr_n == 16'd0) begin
                        state_d = AFTER_PAYLOAD;
                    end else if ({1'b0, hdr_n} > MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        count_d = hdr_n[ADDR_WIDTH:0];
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ in_data;
`endif
                    if (last_byte) begin
                        addr_d  = words_q[ADDR_WIDTH-1:0];
                        words_d = words_inc;
                        if (words_inc == count_q) begin
                            state_d = AFTER_PAYLOAD;
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    state_d = (in_data == chk_q) ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            hdr_hi_q <= '0;
            count_q  <= '0;
            words_q  <= '0;
            addr_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            hdr_hi_q <= hdr_hi_d;
            count_q  <= count_d;
            words_q  <= words_d;
            addr_q   <= addr_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader
//  Directed bench for instr_mem_loader (ADDR_WIDTH=8). Expected memory writes
//  are queued as frames are sent; a monitor pops and compares on every write
//  strobe. Status outputs are compared directly at chosen points.
//  Honours LOADER_CHECKSUM_EN by appending the checksum byte to frames.
module tb_instr_mem_loader;

    localparam int AW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    logic [AW+31:0] exp_q[$];
    logic [31:0]    frame_words[$];
    logic [7:0]     frame_xor;

    instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0d data %h, required no write",
                         imem_addr, imem_wdata);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("[TB] FAIL write: got addr %0d data %h, required addr %0d data %h",
                             imem_addr, imem_wdata, e[AW+31:32], e[31:0]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Offer one byte and wait (bounded) until it is consumed. With gap set an
    // idle cycle follows, giving an in_valid pattern that toggles.
    task automatic applyStimulus(input logic [7:0] b, input bit gap);
        int waited;
        waited = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_timeout: in_ready got 0 for byte %h, required 1", b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            if (gap) @(negedge clk);
        end
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Send the header and payload of frame_words, queueing expected writes.
    // A start pulse is issued mid-payload when poke_start is set.
    task automatic sendFrame(input bit gap, input bit poke_start);
        int n;
        n = frame_words.size();
        frame_xor = 8'h00;
        applyStimulus(n[15:8], gap);
        applyStimulus(n[7:0], gap);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({i[AW-1:0], frame_words[i]});
            for (int k = 0; k < 4; k++) begin
                logic [31:0] w;
                logic [7:0]  b;
                w = frame_words[i];
                b = w[31-8*k -: 8];
                frame_xor ^= b;
                applyStimulus(b, gap);
                if (poke_start && i == 0 && k == 1) begin
                    pulseStart();
                    checkOutput("busy_after_ignored_start", busy, 1);
                    checkOutput("words_after_ignored_start", words_loaded, 0);
                end
            end
        end
        $display("[TB] frame of %0d words sent, payload xor %h", n, frame_xor);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_imem_we"}, imem_we, 0);
        checkOutput({tag, "_imem_addr"}, imem_addr, 0);
        checkOutput({tag, "_imem_wdata"}, imem_wdata, 0);
        checkOutput({tag, "_cpu_rst"}, cpu_rst, 1);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_error"}, error, 0);
        checkOutput({tag, "_words_loaded"}, words_loaded, 0);
    endtask

    task automatic checkDone(input string tag, input int n);
        @(negedge clk);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_cpu_rst"}, cpu_rst, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_words_loaded"}, words_loaded, n);
`ifndef LOADER_CHECKSUM_EN
        if (n > 0) checkOutput({tag, "_last_write_with_done"}, imem_we, 1);
`endif
    endtask

    task automatic finishFrame(input bit gap);
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(frame_xor, gap);
`else
        if (gap) @(negedge clk);
`endif
    endtask

    task automatic loadExample();
        frame_words.delete();
        frame_words.push_back(32'h20080005);
        frame_words.push_back(32'h20090007);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("reset");
        rst = 1'b1;
        @(negedge clk);
        checkReset("post_reset");

        // Example image, back-to-back bytes
        loadExample();
        pulseStart();
        checkOutput("busy_after_start", busy, 1);
        checkOutput("in_ready_after_start", in_ready, 1);
        sendFrame(1'b0, 1'b0);
        finishFrame(1'b0);
        checkDone("example", 2);

        // Restart from DONE, then same image with in_valid toggling and a
        // start pulse in the middle that must be ignored
        pulseStart();
        checkOutput("restart_done", done, 0);
        checkOutput("restart_cpu_rst", cpu_rst, 1);
        checkOutput("restart_words", words_loaded, 0);
        sendFrame(1'b1, 1'b1);
        finishFrame(1'b1);
        if (done !== 1'b1) @(negedge clk);
        checkOutput("toggle_done", done, 1);
        checkOutput("toggle_words", words_loaded, 2);
        checkOutput("toggle_sb_drained", exp_q.size(), 0);

        // Empty image
        pulseStart();
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        applyStimulus(8'h00, 1'b0);
`endif
        @(negedge clk);
        checkOutput("empty_done", done, 1);
        checkOutput("empty_words", words_loaded, 0);

        // Oversized image count
        pulseStart();
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h01, 1'b0);
        @(negedge clk);
        checkOutput("oversize_error", error, 1);
        checkOutput("oversize_in_ready", in_ready, 0);
        checkOutput("oversize_cpu_rst", cpu_rst, 1);
        checkOutput("oversize_busy", busy, 0);

        // Reset in the middle of the first word, then a fresh one-word load
        pulseStart();
        checkOutput("start_from_err_error", error, 0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkReset("midload_reset");
        @(negedge clk);
        rst = 1'b1;
        frame_words.delete();
        frame_words.push_back(32'hDEADBEEF);
        pulseStart();
        sendFrame(1'b0, 1'b0);
        finishFrame(1'b0);
        checkDone("after_reset", 1);

        // Full-depth image: last write must go to the top address
        frame_words.delete();
        for (int i = 0; i < 2 ** AW; i++) begin
            logic [7:0] v;
            v = i[7:0];
            frame_words.push_back({v, ~v, 8'hA5, v ^ 8'h3C});
        end
        pulseStart();
        sendFrame(1'b0, 1'b0);
        finishFrame(1'b0);
        checkDone("full_depth", 2 ** AW);
        checkOutput("full_depth_last_addr", imem_addr, 2 ** AW - 1);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum: writes stay, load ends in error
        loadExample();
        pulseStart();
        sendFrame(1'b0, 1'b0);
        applyStimulus(8'h04, 1'b0);
        @(negedge clk);
        checkOutput("bad_chk_error", error, 1);
        checkOutput("bad_chk_done", done, 0);
        checkOutput("bad_chk_cpu_rst", cpu_rst, 1);
        checkOutput("bad_chk_words", words_loaded, 2);
`endif

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
